led_blink_bank: RTL
===================

// Module: led_blink_bank
// PURPOSE
//  Multi-channel successor to the single LED clock divider. One shared prescaler generates a
//  tick; each of N_CH channels runs its own tick counter in OFF, SOLID, BLINK (programmable
//  period/duty) or ONE-SHOT mode. It sits between the piano/display control logic and the board
//  LEDs, and is configured one channel at a time through a write strobe.
// PARAMETERS
//  N_CH      4      number of LED channels (>=1)
//  CNT_W     11     width of per-channel period/high/counter registers
//  PRE_W     16     width of prescaler counter
//  PRESCALE  50000  clk cycles per tick (2..2^PRE_W)
//  CH_W      (derived localparam) = max(1, clog2(N_CH))
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous active-high reset
//  en          in   1       global enable; low freezes prescaler (no ticks)
//  cfg_we      in   1       config write strobe, one cycle
//  cfg_ch      in   CH_W    channel index for write
//  cfg_mode    in   2       00 OFF, 01 SOLID, 10 BLINK, 11 ONE-SHOT
//  cfg_period  in   CNT_W   BLINK: last count value (period = cfg_period+1 ticks)
//  cfg_high    in   CNT_W   BLINK: on-ticks per period; ONE-SHOT: on-ticks total
//  tick        out  1       one-cycle prescaler pulse (registered)
//  led_out     out  N_CH    LED drive, registered
//  done        out  N_CH    one-cycle pulse when a ONE-SHOT channel expires
// BEHAVIOUR
//  Reset: pre_cnt=0, tick=0; every channel mode=OFF, cnt=0, period=0, high=0; led_out=0, done=0.
//  Prescaler: if en, pre_cnt increments; at pre_cnt==PRESCALE-1 it wraps to 0 and tick=1 next
//   cycle (exactly one cycle). en=0: pre_cnt holds, tick=0. Period = PRESCALE clk exactly.
//  Config: on cfg_we with cfg_ch<N_CH, channel mode/period/high loaded and cnt cleared to 0 on
//   that edge. cfg_ch>=N_CH: write ignored, no state changes. cfg_we on a tick cycle for the
//   same channel: config wins, tick has no effect on that channel; other channels advance.
//  Per-channel update on tick cycle (tick=1 as registered output):
//   OFF/SOLID: cnt held at 0.
//   BLINK: cnt <= (cnt==period) ? 0 : cnt+1. cnt never exceeds period, so no CNT_W overflow.
//   ONE-SHOT: if cnt<high, cnt<=cnt+1; when cnt==high, mode<=OFF, cnt<=0, done pulse.
//  Output (every clk, 1-cycle latency from state): OFF->0; SOLID->1; BLINK->(cnt<high);
//   ONE-SHOT->(cnt<high). Hence high=0 BLINK is dark, high>period BLINK is solid on,
//   period=0 BLINK with high>=1 is solid on.
//  done[c]: registered; high exactly one cycle after the edge where ONE-SHOT expires; ONE-SHOT
//   with high=0 expires on its first tick (LED never lights, done still pulses).
//  Rewriting a channel mid-pattern restarts it from cnt=0; cancels pending ONE-SHOT, no done.
//  rst mid-operation: all state back to reset values on that edge, outstanding done dropped.
// TESTING
//  1 rst held 3 cycles mid-blink -> tick, led_out, done all 0 next cycle; channels OFF.
//  2 PRESCALE=4, ch0 BLINK period=3 high=2, en=1 -> tick every 4 clk; led_out[0] 2 ticks
//    on / 2 ticks off, repeating every 16 clk.
//  3 ch1 ONE-SHOT high=3 -> led_out[1] on for 3 ticks, done[1] single pulse on 4th tick,
//    then led 0 and mode OFF; further ticks produce no done.
//  4 en low for 10 clk during BLINK -> no tick, led_out and cnt frozen; resumes same phase.
//  5 cfg_we to ch0 on a tick cycle -> ch0 cnt=0 with new config, ch2 still advances;
//    cfg_ch=N_CH (when N_CH not power of 2) -> no channel changes.
//  6 BLINK high=0 -> always 0; high=5 period=3 -> always 1; period=2^CNT_W-1 -> wraps to 0 cleanly.

Source files
------------

// File: rtl/led_blink_bank.sv
// Multi-channel LED pattern generator: one shared prescaler tick drives N_CH
// independent OFF / SOLID / BLINK / ONE-SHOT channels, each configured by a write strobe.
module led_blink_bank #(
  parameter  int N_CH     = 4,
  parameter  int CNT_W    = 11,
  parameter  int PRE_W    = 16,
  parameter  int PRESCALE = 50000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             tick,
  output logic [N_CH-1:0]  led_out,
  output logic [N_CH-1:0]  done
);

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_SOLID   = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_ONESHOT = 2'b11;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef struct packed {
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } ch_cfg_t;

  // ---------------- shared prescaler ----------------
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    if (en) begin
      if (pre_cnt_q == PRE_LAST) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

  // ---------------- per-channel pattern engines ----------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             wr, expire;

    // Out-of-range cfg_ch never matches any c, so such writes fall through.
    assign wr = cfg_we && (cfg_ch == CH_W'(c));

    // Next state: a config write outranks the tick for this channel.
    always_comb begin
      cfg_d  = cfg_q;
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (wr) begin
        cfg_d.mode   = cfg_mode;
        cfg_d.period = cfg_period;
        cfg_d.high   = cfg_high;
        cnt_d        = '0;
      end else if (tick_q) begin
        case (cfg_q.mode)
          M_BLINK:   cnt_d = (cnt_q == cfg_q.period) ? '0 : cnt_q + CNT_W'(1);
          M_ONESHOT: begin
            if (cnt_q < cfg_q.high) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cfg_d.mode = M_OFF;
              cnt_d      = '0;
              expire     = 1'b1;
            end
          end
          default:   cnt_d = '0;
        endcase
      end
    end

    // Outputs from current state, registered below.
    always_comb begin
      led_d  = 1'b0;
      done_d = expire;
      case (cfg_q.mode)
        M_SOLID:           led_d = 1'b1;
        M_BLINK, M_ONESHOT: led_d = (cnt_q < cfg_q.high);
        default:           led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cfg_q  <= '0;
        cnt_q  <= '0;
        led_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cfg_q  <= cfg_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
        done_q <= done_d;
      end
    end

    assign led_out[c] = led_q;
    assign done[c]    = done_q;
  end

endmodule
